// File: rtl/mul_div_issue_queue.sv
// In-order issue queue for the mul/div unit: buffers uop pairs, snoops wakeups on their
// four source tags and issues the head entry once all sources are ready.
module mul_div_issue_queue #(
  parameter int unsigned Depth    = 4,
  parameter int unsigned PregW    = 6,
  parameter int unsigned PayloadW = 128,
  parameter int unsigned WakeN    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [PayloadW-1:0]        enq_payload_i,
  input  logic [4*PregW-1:0]         enq_src_tag_i,
  input  logic [3:0]                 enq_src_rdy_i,
  input  logic [WakeN-1:0]           wake_valid_i,
  input  logic [WakeN*PregW-1:0]     wake_tag_i,
  output logic                       issue_valid_o,
  output logic [PayloadW-1:0]        issue_payload_o,
  input  logic                       issue_ready_i,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned PtrW = IdxW + 1;

  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [Depth-1:0]    vld_q, vld_d;
  logic [3:0]          rdy_q [Depth];
  logic [3:0]          rdy_d [Depth];
  logic [4*PregW-1:0]  tag_q [Depth];
  logic [PayloadW-1:0] pay_q [Depth];
  logic [IdxW-1:0]     head_idx, tail_idx;
  logic                full, empty, enq_fire, deq_fire;
  logic [3:0]          enq_rdy;

  function automatic logic woken(input logic [PregW-1:0]       tag,
                                 input logic [WakeN-1:0]       wv,
                                 input logic [WakeN*PregW-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < WakeN; k++) begin
      if (wv[k] && (wt[k*PregW +: PregW] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign head_idx = head_q[IdxW-1:0];
  assign tail_idx = tail_q[IdxW-1:0];
  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign full     = (head_q[PtrW-1] != tail_q[PtrW-1]) && (head_idx == tail_idx);
  assign empty    = (head_q == tail_q);

  assign enq_ready_o     = !full;
  assign issue_valid_o   = !empty && vld_q[head_idx] && (&rdy_q[head_idx]);
  assign issue_payload_o = pay_q[head_idx];
  assign count_o         = tail_q - head_q;

  assign enq_fire = enq_valid_i && !full;
  assign deq_fire = issue_valid_o && issue_ready_i;

  // A wakeup coinciding with dispatch is captured directly into the new entry.
  always_comb begin
    enq_rdy = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      enq_rdy[i] = enq_src_rdy_i[i] |
                   woken(enq_src_tag_i[i*PregW +: PregW], wake_valid_i, wake_tag_i);
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d  = vld_q;
    rdy_d  = rdy_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      vld_d  = '0;
      for (int unsigned e = 0; e < Depth; e++) rdy_d[e] = '0;
    end else begin
      for (int unsigned e = 0; e < Depth; e++) begin
        if (vld_q[e]) begin
          for (int unsigned i = 0; i < 4; i++) begin
            if (woken(tag_q[e][i*PregW +: PregW], wake_valid_i, wake_tag_i)) begin
              rdy_d[e][i] = 1'b1;
            end
          end
        end
      end
      if (deq_fire) begin
        head_d          = head_q + PtrW'(1);
        vld_d[head_idx] = 1'b0;
        rdy_d[head_idx] = '0;
      end
      if (enq_fire) begin
        tail_d          = tail_q + PtrW'(1);
        vld_d[tail_idx] = 1'b1;
        rdy_d[tail_idx] = enq_rdy;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
      for (int unsigned e = 0; e < Depth; e++) begin
        rdy_q[e] <= '0;
        tag_q[e] <= '0;
        pay_q[e] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
      rdy_q  <= rdy_d;
      if (enq_fire && !flush_i) begin
        tag_q[tail_idx] <= enq_src_tag_i;
        pay_q[tail_idx] <= enq_payload_i;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_issue_queue.sv
// Scoreboard bench for mul_div_issue_queue: expected payloads are queued at dispatch and
// a negedge monitor compares every issued payload in program order.
module tb_mul_div_issue_queue;

  localparam int unsigned Depth    = 4;
  localparam int unsigned PregW    = 6;
  localparam int unsigned PayloadW = 128;
  localparam int unsigned WakeN    = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic                   enq_valid;
  logic                   enq_ready;
  logic [PayloadW-1:0]    enq_payload;
  logic [4*PregW-1:0]     enq_src_tag;
  logic [3:0]             enq_src_rdy;
  logic [WakeN-1:0]       wake_valid;
  logic [WakeN*PregW-1:0] wake_tag;
  logic                   issue_valid;
  logic [PayloadW-1:0]    issue_payload;
  logic                   issue_ready;
  logic [2:0]             count;

  logic [PayloadW-1:0] sb[$];
  int errors = 0;
  int checks = 0;

  mul_div_issue_queue #(
    .Depth    (Depth),
    .PregW    (PregW),
    .PayloadW (PayloadW),
    .WakeN    (WakeN)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .enq_valid_i     (enq_valid),
    .enq_ready_o     (enq_ready),
    .enq_payload_i   (enq_payload),
    .enq_src_tag_i   (enq_src_tag),
    .enq_src_rdy_i   (enq_src_rdy),
    .wake_valid_i    (wake_valid),
    .wake_tag_i      (wake_tag),
    .issue_valid_o   (issue_valid),
    .issue_payload_o (issue_payload),
    .issue_ready_i   (issue_ready),
    .count_o         (count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted issue must match the oldest expected payload.
  always @(negedge clk) begin
    if (rst_n && !flush && issue_valid && issue_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got payload %h, required no issue", issue_payload);
      end else begin
        logic [PayloadW-1:0] exp;
        exp = sb.pop_front();
        if (issue_payload !== exp) begin
          errors++;
          $display("FAIL issue_order: got payload %h, required %h", issue_payload, exp);
        end
      end
    end
  end

  function automatic logic [PayloadW-1:0] mkp(input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 | n;
    return {w, ~w, w ^ 32'h5A5A_5A5A, w};
  endfunction

  function automatic logic [4*PregW-1:0] tags(input int hi, input int lo, input int rs,
                                              input int rt);
    return {PregW'(rt), PregW'(rs), PregW'(lo), PregW'(hi)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive_enq(input int n, input logic [4*PregW-1:0] t, input logic [3:0] r,
                           input bit expect_issue);
    enq_valid   = 1'b1;
    enq_payload = mkp(n);
    enq_src_tag = t;
    enq_src_rdy = r;
    if (expect_issue) sb.push_back(mkp(n));
  endtask

  task automatic idle_enq();
    enq_valid   = 1'b0;
    enq_payload = '0;
    enq_src_tag = '0;
    enq_src_rdy = '0;
  endtask

  task automatic wake(input int port, input int tag);
    wake_valid       = '0;
    wake_tag         = '0;
    wake_valid[port] = 1'b1;
    wake_tag[port*PregW +: PregW] = PregW'(tag);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 10 && count != 0; n++) tick();
    chk(name, count, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    issue_ready = 1'b0;
    wake_valid = '0;
    wake_tag = '0;
    idle_enq();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_enq_ready", enq_ready, 1);
    chk("reset_issue_valid", issue_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_payload", issue_payload, 0);
    rst_n = 1'b1;
    tick();

    // 1: single fully-ready pair issues the cycle after enqueue.
    issue_ready = 1'b1;
    drive_enq(1, tags(1, 2, 3, 4), 4'b1111, 1);
    tick();
    idle_enq();
    chk("t1_issue_valid", issue_valid, 1);
    chk("t1_count", count, 1);
    tick();
    chk("t1_count_after", count, 0);

    // 2: fill to full, hold a 5th, then drain across the pointer wrap.
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_enq(10 + i, tags(i, i, i, i), 4'b1111, 1);
      tick();
    end
    drive_enq(14, tags(5, 5, 5, 5), 4'b1111, 0);
    chk("t2_count_full", count, 4);
    chk("t2_enq_ready_full", enq_ready, 0);
    tick();
    tick();
    chk("t2_count_held", count, 4);
    issue_ready = 1'b1;
    sb.push_back(mkp(14));
    tick();
    chk("t2_count_first_deq", count, 3);
    tick();
    chk("t2_count_enq_deq", count, 3);
    idle_enq();
    drain("t2_drain");

    // 3: pending rt tag 9 woken at T issues at T+1.
    drive_enq(20, tags(1, 2, 3, 9), 4'b0111, 1);
    tick();
    idle_enq();
    chk("t3_wait", issue_valid, 0);
    tick();
    chk("t3_wait2", issue_valid, 0);
    wake(2, 9);
    chk("t3_same_cycle", issue_valid, 0);
    tick();
    wake_valid = '0;
    chk("t3_issue_t1", issue_valid, 1);
    tick();
    chk("t3_count", count, 0);

    // 4: wakeup coinciding with dispatch is not lost.
    drive_enq(30, tags(0, 0, 12, 0), 4'b1011, 1);
    wake(0, 12);
    tick();
    idle_enq();
    wake_valid = '0;
    chk("t4_issue", issue_valid, 1);
    tick();
    chk("t4_count", count, 0);

    // 5: younger ready entry waits behind a blocked head.
    drive_enq(40, tags(20, 21, 22, 23), 4'b1110, 1);
    tick();
    drive_enq(41, tags(1, 1, 1, 1), 4'b1111, 1);
    tick();
    idle_enq();
    chk("t5_blocked", issue_valid, 0);
    chk("t5_count2", count, 2);
    tick();
    chk("t5_still_blocked", issue_valid, 0);
    wake(3, 20);
    tick();
    wake_valid = '0;
    chk("t5_head_ready", issue_valid, 1);
    chk("t5_count_before", count, 2);
    tick();
    chk("t5_second_ready", issue_valid, 1);
    chk("t5_count1", count, 1);
    tick();
    chk("t5_count0", count, 0);

    // 6: flush discards queued entries and the same-cycle enqueue.
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_enq(50 + i, tags(2, 2, 2, 2), 4'b1111, 1);
      tick();
    end
    idle_enq();
    chk("t6_count3", count, 3);
    drive_enq(53, tags(2, 2, 2, 2), 4'b1111, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_enq();
    sb.delete();
    chk("t6_flush_count", count, 0);
    chk("t6_flush_issue", issue_valid, 0);
    chk("t6_flush_enq_ready", enq_ready, 1);
    issue_ready = 1'b1;
    tick();
    tick();
    chk("t6_no_ghost", issue_valid, 0);

    // Asynchronous reset mid-cycle.
    issue_ready = 1'b0;
    drive_enq(60, tags(3, 3, 3, 3), 4'b1111, 1);
    tick();
    idle_enq();
    chk("t6_pre_reset_count", count, 1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_areset_count", count, 0);
    chk("t6_areset_issue", issue_valid, 0);
    chk("t6_areset_enq_ready", enq_ready, 1);
    chk("t6_areset_payload", issue_payload, 0);
    #1;
    rst_n = 1'b1;
    tick();

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
